// File: rtl/tdp_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// tdp_port_arbiter_if
//   Requester-side bundle for the dual-port arbiter: one valid/ready request
//   channel plus read-return channel for each of the logical ports A and B.
//
//   Per port x in {a, b}:
//     x_valid  requester -> arbiter  request valid
//     x_ready  arbiter -> requester  request accepted this cycle
//     x_we     requester -> arbiter  1 = write, 0 = read
//     x_addr   requester -> arbiter  request address
//     x_wdata  requester -> arbiter  write data
//     x_be     requester -> arbiter  byte-lane write enables
//     x_rvalid arbiter -> requester  x_rdata is fresh this cycle
//     x_rdata  arbiter -> requester  read data (held between reads)
//
//   Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface tdp_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36,
  parameter int BYTEWIDTH  = 9
);
  localparam int BE_W = DATA_WIDTH / BYTEWIDTH;

  logic                  a_valid;
  logic                  a_ready;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [BE_W-1:0]       a_be;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_valid;
  logic                  b_ready;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic [BE_W-1:0]       b_be;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  modport master (
    output a_valid, a_we, a_addr, a_wdata, a_be,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_we, b_addr, b_wdata, b_be,
    input  b_ready, b_rvalid, b_rdata
  );

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata, a_be,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_we, b_addr, b_wdata, b_be,
    output b_ready, b_rvalid, b_rdata
  );
endinterface

// File: rtl/tdp_port_arbiter.sv
// ----------------------------------------------------------------------------
// tdp_port_arbiter
//   Request-side front end for a split true-dual-port BRAM. Requests on
//   logical ports A and B pass combinationally to RAM ports A and B. When
//   both ports hit the same address and at least one of them writes, only
//   one port is granted; the grant alternates between collisions so neither
//   side starves. Read data returns one cycle after issue and is held
//   stable until the next read on that port.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req               tdp_port_arbiter_if.slave, requester channels A and B
//   ram_x_re/we       RAM port x read / write enable (x in a, b)
//   ram_x_addr/wd/be  RAM port x address, write data, byte enables
//   ram_x_rd          RAM port x read data, valid 1 cycle after ram_x_re
//   conflict          pulse: a collision was arbitrated this cycle
//   conflict_cnt      saturating collision count (TDP_ARB_STATS_EN only)
//
// Optional feature macro: TDP_ARB_STATS_EN adds the conflict_cnt output.
// ----------------------------------------------------------------------------
module tdp_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36,
  parameter int BYTEWIDTH  = 9
) (
  input  logic                              clk,
  input  logic                              rst_n,
  tdp_port_arbiter_if.slave                 req,

  output logic                              ram_a_re,
  output logic                              ram_a_we,
  output logic [ADDR_WIDTH-1:0]             ram_a_addr,
  output logic [DATA_WIDTH-1:0]             ram_a_wd,
  output logic [DATA_WIDTH/BYTEWIDTH-1:0]   ram_a_be,
  input  logic [DATA_WIDTH-1:0]             ram_a_rd,

  output logic                              ram_b_re,
  output logic                              ram_b_we,
  output logic [ADDR_WIDTH-1:0]             ram_b_addr,
  output logic [DATA_WIDTH-1:0]             ram_b_wd,
  output logic [DATA_WIDTH/BYTEWIDTH-1:0]   ram_b_be,
  input  logic [DATA_WIDTH-1:0]             ram_b_rd,

`ifdef TDP_ARB_STATS_EN
  output logic [15:0]                       conflict_cnt,
`endif
  output logic                              conflict
);

  if (DATA_WIDTH % BYTEWIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTEWIDTH");
  end

  // Which port took the most recent collision; the other one takes the next.
  typedef enum logic {
    WIN_A = 1'b0,
    WIN_B = 1'b1
  } win_e;

  win_e                  last_win;
  logic                  collide;
  logic                  a_grant;
  logic                  b_grant;
  logic                  rv_a;
  logic                  rv_b;
  logic [DATA_WIDTH-1:0] hold_a;
  logic [DATA_WIDTH-1:0] hold_b;

  // --------------------------------------------------------------------------
  // Arbitration and issue (combinational)
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    collide  = 1'b0;
    a_grant  = 1'b0;
    b_grant  = 1'b0;

    collide = req.a_valid & req.b_valid & (req.a_addr == req.b_addr)
            & (req.a_we | req.b_we);

    // Without a collision both sides are ready; with one, only the port
    // that did not win last time. Everything is gated off while in reset.
    a_grant = rst_n & (~collide | (last_win == WIN_B));
    b_grant = rst_n & (~collide | (last_win == WIN_A));
  end

  assign req.a_ready = a_grant;
  assign req.b_ready = b_grant;
  assign conflict    = rst_n & collide;

  assign ram_a_we    = req.a_valid & a_grant &  req.a_we;
  assign ram_a_re    = req.a_valid & a_grant & ~req.a_we;
  assign ram_b_we    = req.b_valid & b_grant &  req.b_we;
  assign ram_b_re    = req.b_valid & b_grant & ~req.b_we;

  // Address, data and lanes are don't-care unless an enable is set, so they
  // go straight through; a write with no lanes enabled is still issued.
  assign ram_a_addr  = req.a_addr;
  assign ram_a_wd    = req.a_wdata;
  assign ram_a_be    = req.a_be;
  assign ram_b_addr  = req.b_addr;
  assign ram_b_wd    = req.b_wdata;
  assign ram_b_be    = req.b_be;

  // --------------------------------------------------------------------------
  // State: grant history and read-return tracking
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_win <= WIN_B;             // A wins the first collision
      rv_a     <= 1'b0;
      rv_b     <= 1'b0;
      hold_a   <= '0;
      hold_b   <= '0;
    end else begin
      if (collide) begin
        last_win <= (last_win == WIN_B) ? WIN_A : WIN_B;
      end
      rv_a <= ram_a_re;
      rv_b <= ram_b_re;
      // Capture the RAM output in the cycle it is valid so it can be
      // replayed while no new read is returning.
      if (rv_a) hold_a <= ram_a_rd;
      if (rv_b) hold_b <= ram_b_rd;
    end
  end

  assign req.a_rvalid = rv_a;
  assign req.b_rvalid = rv_b;
  assign req.a_rdata  = rv_a ? ram_a_rd : hold_a;
  assign req.b_rdata  = rv_b ? ram_b_rd : hold_b;

`ifdef TDP_ARB_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating collision counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (collide && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdp_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tdp_port_arbiter
//   Self-checking bench for tdp_port_arbiter. Contains a behavioural BRAM
//   that answers the DUT's RAM pins, and a reference model that predicts
//   grants, issue enables and returned read data from the arbitration rules.
//   Define TDP_ARB_STATS_EN to also check conflict_cnt.
// ----------------------------------------------------------------------------
module tb_tdp_port_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 36;
  localparam int BW   = 9;
  localparam int BE_W = DW / BW;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst_n;

  logic            ram_a_re, ram_a_we, ram_b_re, ram_b_we;
  logic [AW-1:0]   ram_a_addr, ram_b_addr;
  logic [DW-1:0]   ram_a_wd, ram_b_wd, ram_a_rd, ram_b_rd;
  logic [BE_W-1:0] ram_a_be, ram_b_be;
  logic            conflict;
`ifdef TDP_ARB_STATS_EN
  logic [15:0]     conflict_cnt;
`endif

  tdp_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTEWIDTH(BW)) bus ();

  tdp_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTEWIDTH(BW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (bus),
    .ram_a_re   (ram_a_re),
    .ram_a_we   (ram_a_we),
    .ram_a_addr (ram_a_addr),
    .ram_a_wd   (ram_a_wd),
    .ram_a_be   (ram_a_be),
    .ram_a_rd   (ram_a_rd),
    .ram_b_re   (ram_b_re),
    .ram_b_we   (ram_b_we),
    .ram_b_addr (ram_b_addr),
    .ram_b_wd   (ram_b_wd),
    .ram_b_be   (ram_b_be),
    .ram_b_rd   (ram_b_rd),
`ifdef TDP_ARB_STATS_EN
    .conflict_cnt (conflict_cnt),
`endif
    .conflict   (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Behavioural BRAM driven by whatever the DUT issues
  // --------------------------------------------------------------------------
  logic [DW-1:0] ram_mem [DEPTH];

  always @(posedge clk) begin
    if (ram_a_we)
      for (int l = 0; l < BE_W; l++)
        if (ram_a_be[l]) ram_mem[ram_a_addr][l*BW +: BW] <= ram_a_wd[l*BW +: BW];
    if (ram_b_we)
      for (int l = 0; l < BE_W; l++)
        if (ram_b_be[l]) ram_mem[ram_b_addr][l*BW +: BW] <= ram_b_wd[l*BW +: BW];
    if (ram_a_re) ram_a_rd <= ram_mem[ram_a_addr];
    if (ram_b_re) ram_b_rd <= ram_mem[ram_b_addr];
  end

  // --------------------------------------------------------------------------
  // Reference model state
  // --------------------------------------------------------------------------
  logic [DW-1:0] ref_mem [DEPTH];
  bit            a_next;        // 1: A takes the next collision
  bit            exp_rv_a, exp_rv_b;
  logic [DW-1:0] exp_rd_a, exp_rd_b;
  int            exp_cnt;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    a_next   = 1'b1;
    exp_rv_a = 1'b0;
    exp_rv_b = 1'b0;
    exp_rd_a = '0;
    exp_rd_b = '0;
    exp_cnt  = 0;
  endtask

  task automatic poke(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ram_mem[addr] = data;
    ref_mem[addr] = data;
  endtask

  task automatic set_a(input bit v, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [BE_W-1:0] be);
    bus.a_valid = v; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd; bus.a_be = be;
  endtask

  task automatic set_b(input bit v, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [BE_W-1:0] be);
    bus.b_valid = v; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd; bus.b_be = be;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, '0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Assert reset mid-cycle, check the forced outputs, release on a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst a_rvalid", 64'(bus.a_rvalid), 64'(0));
    check("rst b_rvalid", 64'(bus.b_rvalid), 64'(0));
    check("rst a_rdata",  64'(bus.a_rdata),  64'(0));
    check("rst b_rdata",  64'(bus.b_rdata),  64'(0));
    check("rst conflict", 64'(conflict),     64'(0));
    check("rst a_ready",  64'(bus.a_ready),  64'(0));
    check("rst b_ready",  64'(bus.b_ready),  64'(0));
    check("rst ram_a_en", 64'({ram_a_re, ram_a_we}), 64'(0));
    check("rst ram_b_en", 64'({ram_b_re, ram_b_we}), 64'(0));
`ifdef TDP_ARB_STATS_EN
    check("rst conflict_cnt", 64'(conflict_cnt), 64'(0));
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock with the currently driven request; called on a negedge.
  task automatic cycle();
    bit col, rdy_a, rdy_b, iss_a, iss_b;
    bit a_we_s, b_we_s;
    logic [AW-1:0]   a_ad, b_ad;
    logic [DW-1:0]   a_wd, b_wd;
    logic [BE_W-1:0] a_be, b_be;
    #1;
    a_we_s = bus.a_we;  b_we_s = bus.b_we;
    a_ad = bus.a_addr;  b_ad = bus.b_addr;
    a_wd = bus.a_wdata; b_wd = bus.b_wdata;
    a_be = bus.a_be;    b_be = bus.b_be;

    col   = bus.a_valid && bus.b_valid && (a_ad == b_ad) && (a_we_s || b_we_s);
    rdy_a = !col || a_next;
    rdy_b = !col || !a_next;
    iss_a = bus.a_valid && rdy_a;
    iss_b = bus.b_valid && rdy_b;

    check("a_ready",  64'(bus.a_ready), 64'(rdy_a));
    check("b_ready",  64'(bus.b_ready), 64'(rdy_b));
    check("conflict", 64'(conflict),    64'(col));
    check("ram_a_re", 64'(ram_a_re), 64'(iss_a && !a_we_s));
    check("ram_a_we", 64'(ram_a_we), 64'(iss_a &&  a_we_s));
    check("ram_b_re", 64'(ram_b_re), 64'(iss_b && !b_we_s));
    check("ram_b_we", 64'(ram_b_we), 64'(iss_b &&  b_we_s));
    check("ram_a_addr", 64'(ram_a_addr), 64'(a_ad));
    check("ram_b_addr", 64'(ram_b_addr), 64'(b_ad));
    check("ram_a_wd",   64'(ram_a_wd),   64'(a_wd));
    check("ram_b_wd",   64'(ram_b_wd),   64'(b_wd));
    check("ram_a_be",   64'(ram_a_be),   64'(a_be));
    check("ram_b_be",   64'(ram_b_be),   64'(b_be));

    @(posedge clk);
    // Reads and writes on one address never share a cycle, so order is free.
    exp_rv_a = iss_a && !a_we_s;
    exp_rv_b = iss_b && !b_we_s;
    if (exp_rv_a) exp_rd_a = ref_mem[a_ad];
    if (exp_rv_b) exp_rd_b = ref_mem[b_ad];
    for (int l = 0; l < BE_W; l++) begin
      if (iss_a && a_we_s && a_be[l]) ref_mem[a_ad][l*BW +: BW] = a_wd[l*BW +: BW];
      if (iss_b && b_we_s && b_be[l]) ref_mem[b_ad][l*BW +: BW] = b_wd[l*BW +: BW];
    end
    if (col) begin
      a_next = !a_next;
      if (exp_cnt < 16'hFFFF) exp_cnt++;
    end

    #1;
    check("a_rvalid", 64'(bus.a_rvalid), 64'(exp_rv_a));
    check("b_rvalid", 64'(bus.b_rvalid), 64'(exp_rv_b));
    check("a_rdata",  64'(bus.a_rdata),  64'(exp_rd_a));
    check("b_rdata",  64'(bus.b_rdata),  64'(exp_rd_b));
`ifdef TDP_ARB_STATS_EN
    check("conflict_cnt", 64'(conflict_cnt), 64'(exp_cnt));
`endif
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Directed steps followed by randomized traffic
  // --------------------------------------------------------------------------
  initial begin
    logic [63:0] r;
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    ram_a_rd = '0;
    ram_b_rd = '0;
    idle();
    set_a(1'b1, 1'b0, 10'h005, '0, '0);   // request present during reset
    do_reset();

    // Read with 1-cycle latency, then data held with rvalid low.
    poke(10'h005, 36'h1_2345_6789);
    set_a(1'b1, 1'b0, 10'h005, '0, '0);
    cycle();
    check("read 0x005 data", 64'(bus.a_rdata), 64'(36'h1_2345_6789));
    idle();
    cycle();
    cycle();
    check("held 0x005 data", 64'(bus.a_rdata), 64'(36'h1_2345_6789));

    // Write/read collision: A wins, held B read goes next and sees new data.
    set_a(1'b1, 1'b1, 10'h010, 36'hA_BCDE_F012, 4'hF);
    set_b(1'b1, 1'b0, 10'h010, '0, '0);
    cycle();
    set_a(1'b0, 1'b0, '0, '0, '0);
    cycle();
    check("B reads new data", 64'(bus.b_rdata), 64'(36'hA_BCDE_F012));

    // Fresh reset, then three write/write collisions on 0x3FF: A, B, A.
    set_a(1'b1, 1'b1, 10'h3FF, 36'h0_0000_0AAA, 4'hF);
    set_b(1'b1, 1'b1, 10'h3FF, 36'h0_0000_0BBB, 4'hF);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.a_wdata = 36'(i + 'h100);
      bus.b_wdata = 36'(i + 'h200);
      cycle();
    end
`ifdef TDP_ARB_STATS_EN
    check("conflict_cnt after 3", 64'(conflict_cnt), 64'(3));
`endif

    // Read/read on the same address: both granted, no conflict.
    poke(10'h020, 36'h5_5555_AAAA);
    set_a(1'b1, 1'b0, 10'h020, '0, '0);
    set_b(1'b1, 1'b0, 10'h020, '0, '0);
    cycle();

    // Partial-lane write alongside a write to another address.
    set_a(1'b1, 1'b1, 10'h001, 36'hF_FFFF_FFFF, 4'b0101);
    set_b(1'b1, 1'b1, 10'h002, 36'h1_1111_1111, 4'hF);
    cycle();
    set_a(1'b1, 1'b0, 10'h001, '0, '0);
    set_b(1'b1, 1'b0, 10'h002, '0, '0);
    cycle();
    check("partial lanes 0x001", 64'(bus.a_rdata), 64'(36'h0_07FC_01FF));

    // Reset while a read is returning, then A wins the first collision.
    set_a(1'b1, 1'b0, 10'h005, '0, '0);
    set_b(1'b0, 1'b0, '0, '0, '0);
    cycle();
    do_reset();
    set_a(1'b1, 1'b1, 10'h0AA, 36'h3, 4'hF);
    set_b(1'b1, 1'b0, 10'h0AA, '0, '0);
    cycle();

    // Randomized traffic over a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      r = {$urandom(), $urandom()};
      set_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            10'($urandom_range(0, 3)), r[35:0], 4'($urandom_range(0, 15)));
      r = {$urandom(), $urandom()};
      set_b(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            10'($urandom_range(0, 3)), r[35:0], 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
